// File: rtl/moore_run_scheduler.sv
// Shared consecutive-ones run detector, time-multiplexed over NCH channels.
// Round-robin grant picks one channel per cycle to advance its saved count.
module moore_run_scheduler #(
  parameter int NCH     = 4,
  parameter int RUN_LEN = 2
) (
  input  logic                   Clock,
  input  logic                   Resetn,
  input  logic [NCH-1:0]         req,
  input  logic [NCH-1:0]         w,
  input  logic [NCH-1:0]         clr,
  output logic [NCH-1:0]         gnt,
  output logic [NCH-1:0]         z,
  output logic                   hit,
  output logic [$clog2(NCH)-1:0] hit_ch
);

  localparam int PW = $clog2(NCH);
  localparam logic [3:0] RL = 4'(RUN_LEN);

  logic [3:0]    cnt [NCH];
  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic          gvalid;
  logic          enter;

  // Search starts at ptr; PW-bit add wraps since NCH is a power of 2.
  always_comb begin
    gvalid = 1'b0;
    gidx   = '0;
    for (int k = 0; k < NCH; k++) begin
      if (!gvalid && req[ptr + PW'(k)]) begin
        gvalid = 1'b1;
        gidx   = ptr + PW'(k);
      end
    end
    if (!Resetn) gvalid = 1'b0;
  end

  assign gnt = gvalid ? (NCH'(1) << gidx) : '0;

  assign enter = gvalid && !clr[gidx] && w[gidx] &&
                 (cnt[gidx] == RL - 4'd1);

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      z[i] = (cnt[i] == RL);
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
      end
      ptr    <= '0;
      hit    <= 1'b0;
      hit_ch <= '0;
    end else begin
      if (gvalid) ptr <= gidx + PW'(1);
      for (int i = 0; i < NCH; i++) begin
        if (clr[i]) begin
          cnt[i] <= '0;
        end else if (gvalid && gidx == PW'(i)) begin
          if (!w[i])            cnt[i] <= '0;
          else if (cnt[i] != RL) cnt[i] <= cnt[i] + 4'd1;
        end
      end
      hit <= enter;
      if (enter) hit_ch <= gidx;
    end
  end

endmodule
